// File: rtl/ugv_pkg.sv
// Shared types for the UGV command sequencer: motion commands, FSM states,
// speed-code limits and the command-to-direction mapping.
package ugv_pkg;

  localparam int unsigned SPD_W   = 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_REV   = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4
  } cmd_e;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    RAMP_DOWN = 3'd2,
    HOLD      = 3'd3
  } state_e;

  localparam logic [SPD_W-1:0] SPD_MIN = 2'd0;
  localparam logic [SPD_W-1:0] SPD_MAX = 2'd3;

  // Returns {dir_a, dir_b}; 1 = forward for that motor.
  function automatic logic [1:0] cmd_dirs(input cmd_e c);
    case (c)
      CMD_FWD:   return 2'b11;
      CMD_REV:   return 2'b00;
      CMD_LEFT:  return 2'b01;
      CMD_RIGHT: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ugv_cmd_sequencer_if.sv
// Button/speed inputs and motor-command outputs of the sequencer.
// heartbeat exists only when UGV_SEQ_WATCHDOG_EN is defined.
interface ugv_cmd_sequencer_if;

  logic                        btn_f;
  logic                        btn_b;
  logic                        btn_l;
  logic                        btn_r;
  logic [ugv_pkg::SPD_W-1:0]   speed_max;
  logic [ugv_pkg::SPD_W-1:0]   speed_code;
  logic                        motor_en;
  logic                        dir_a;
  logic                        dir_b;
  logic [ugv_pkg::STATE_W-1:0] state;
  logic                        fault;
`ifdef UGV_SEQ_WATCHDOG_EN
  logic                        heartbeat;
`endif

  modport master (
`ifdef UGV_SEQ_WATCHDOG_EN
    output heartbeat,
`endif
    output btn_f, btn_b, btn_l, btn_r, speed_max,
    input  speed_code, motor_en, dir_a, dir_b, state, fault
  );

  modport slave (
`ifdef UGV_SEQ_WATCHDOG_EN
    input  heartbeat,
`endif
    input  btn_f, btn_b, btn_l, btn_r, speed_max,
    output speed_code, motor_en, dir_a, dir_b, state, fault
  );

endinterface

// File: rtl/ugv_debounce.sv
// One button: 2-FF synchroniser followed by a consecutive-sample debouncer.
module ugv_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic db
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q, sync_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only advances while the synchronised level disagrees with db.
  always_comb begin
    sync_d = {sync_q[0], btn};
    db_d   = db_q;
    cnt_d  = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/ugv_cmd_sequencer.sv
// Button-to-motion command sequencer with speed ramping and a ramp-down/hold
// interlock before direction changes. UGV_SEQ_WATCHDOG_EN adds a heartbeat watchdog.
module ugv_cmd_sequencer
  import ugv_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 50000,
  parameter int unsigned RAMP_STEP_CYCLES = 250000,
  parameter int unsigned STOP_HOLD_CYCLES = 100000
`ifdef UGV_SEQ_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES      = 5000000
`endif
) (
  input logic                clk,
  input logic                reset,
  ugv_cmd_sequencer_if.slave bus
);

  localparam int unsigned RW = $clog2(RAMP_STEP_CYCLES);
  localparam int unsigned HW = $clog2(STOP_HOLD_CYCLES);

  logic db_f, db_b, db_l, db_r;

  ugv_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_f (.clk(clk), .reset(reset), .btn(bus.btn_f), .db(db_f));
  ugv_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (.clk(clk), .reset(reset), .btn(bus.btn_b), .db(db_b));
  ugv_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (.clk(clk), .reset(reset), .btn(bus.btn_l), .db(db_l));
  ugv_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (.clk(clk), .reset(reset), .btn(bus.btn_r), .db(db_r));

  state_e           state_q, state_d;
  cmd_e             active_q, active_d;
  logic [SPD_W-1:0] speed_q, speed_d;
  logic             motor_en_q, motor_en_d;
  logic             dir_a_q, dir_a_d;
  logic             dir_b_q, dir_b_d;
  logic             fault_q, fault_d;
  logic [RW-1:0]    ramp_cnt_q, ramp_cnt_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;

  logic [2:0]       n_pressed_c;
  logic             multi_c;
  logic             tick_c;
  cmd_e             cmd_c;

`ifdef UGV_SEQ_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES);
  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_trip_q, wdog_trip_d;

  // Counter saturates at the timeout so the trip stays set until a heartbeat.
  always_comb begin
    wdog_cnt_d  = wdog_cnt_q + WW'(1);
    wdog_trip_d = wdog_trip_q;
    if (bus.heartbeat) begin
      wdog_cnt_d  = '0;
      wdog_trip_d = 1'b0;
    end else if (wdog_cnt_q == WW'(WDOG_CYCLES - 1)) begin
      wdog_cnt_d  = wdog_cnt_q;
      wdog_trip_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end
`endif

  // Decode debounced buttons; anything but exactly one pressed is NONE.
  always_comb begin
    n_pressed_c = 3'(db_f) + 3'(db_b) + 3'(db_l) + 3'(db_r);
    multi_c     = (n_pressed_c > 3'd1);
    cmd_c       = CMD_NONE;
    if (n_pressed_c == 3'd1) begin
      if (db_f)      cmd_c = CMD_FWD;
      else if (db_b) cmd_c = CMD_REV;
      else if (db_l) cmd_c = CMD_LEFT;
      else           cmd_c = CMD_RIGHT;
    end
`ifdef UGV_SEQ_WATCHDOG_EN
    if (wdog_trip_q) cmd_c = CMD_NONE;
`endif
  end

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    speed_d    = speed_q;
    motor_en_d = motor_en_q;
    dir_a_d    = dir_a_q;
    dir_b_d    = dir_b_q;
    tick_c     = (ramp_cnt_q == RW'(RAMP_STEP_CYCLES - 1));

    case (state_q)
      IDLE: begin
        motor_en_d = 1'b0;
        speed_d    = SPD_MIN;
        if (cmd_c != CMD_NONE) begin
          active_d             = cmd_c;
          {dir_a_d, dir_b_d}   = cmd_dirs(cmd_c);
          motor_en_d           = 1'b1;
          state_d              = RUN;
        end
      end
      RUN: begin
        if (cmd_c != active_q) begin
          state_d = RAMP_DOWN;
        end else if (tick_c) begin
          if (speed_q < bus.speed_max && speed_q != SPD_MAX) begin
            speed_d = speed_q + 2'd1;
          end else if (speed_q > bus.speed_max && speed_q != SPD_MIN) begin
            speed_d = speed_q - 2'd1;
          end
        end
      end
      RAMP_DOWN: begin
        // Returning to the original command resumes without a hold.
        if (cmd_c == active_q) begin
          state_d = RUN;
        end else if (tick_c) begin
          if (speed_q == SPD_MIN) begin
            state_d    = HOLD;
            motor_en_d = 1'b0;
          end else begin
            speed_d = speed_q - 2'd1;
          end
        end
      end
      HOLD: begin
        motor_en_d = 1'b0;
        speed_d    = SPD_MIN;
        if (hold_cnt_q == HW'(STOP_HOLD_CYCLES - 1)) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        motor_en_d = 1'b0;
        speed_d    = SPD_MIN;
      end
    endcase

    ramp_cnt_d = (state_d != state_q || tick_c) ? '0 : ramp_cnt_q + RW'(1);
    hold_cnt_d = (state_q == HOLD && state_d == HOLD) ? hold_cnt_q + HW'(1) : '0;
`ifdef UGV_SEQ_WATCHDOG_EN
    fault_d    = multi_c | wdog_trip_q;
`else
    fault_d    = multi_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      active_q   <= CMD_NONE;
      speed_q    <= SPD_MIN;
      motor_en_q <= 1'b0;
      dir_a_q    <= 1'b0;
      dir_b_q    <= 1'b0;
      fault_q    <= 1'b0;
      ramp_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      speed_q    <= speed_d;
      motor_en_q <= motor_en_d;
      dir_a_q    <= dir_a_d;
      dir_b_q    <= dir_b_d;
      fault_q    <= fault_d;
      ramp_cnt_q <= ramp_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.speed_code = speed_q;
  assign bus.motor_en   = motor_en_q;
  assign bus.dir_a      = dir_a_q;
  assign bus.dir_b      = dir_b_q;
  assign bus.state      = state_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_ugv_cmd_sequencer.sv
// Bench for ugv_cmd_sequencer: directed scenarios plus random button traffic,
// checked every cycle against a behavioural model and a few literal timings.
module tb_ugv_cmd_sequencer;

  localparam int unsigned DB = 4;
  localparam int unsigned RS = 8;
  localparam int unsigned SH = 16;
  localparam int unsigned WD = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   hb_en = 1'b1;

  ugv_cmd_sequencer_if bus ();

  ugv_cmd_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .RAMP_STEP_CYCLES(RS),
    .STOP_HOLD_CYCLES(SH)
`ifdef UGV_SEQ_WATCHDOG_EN
    ,
    .WDOG_CYCLES     (WD)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [DB:0] hist [4];
  bit        mdb  [4];
  int        m_phase, m_age, m_act, m_spd, m_since;
  bit        m_en, m_da, m_dbd, m_fault, m_trip;

  function automatic bit [1:0] dirs_of(input int c);
    case (c)
      1: return 2'b11;
      2: return 2'b00;
      3: return 2'b01;
      4: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int n, c, np;
    bit tick, all_diff;
    bit [3:0] raw;
    raw = {bus.btn_r, bus.btn_l, bus.btn_b, bus.btn_f};
    if (reset) begin
      for (int i = 0; i < 4; i++) begin hist[i] = '0; mdb[i] = 1'b0; end
      m_phase = 0; m_age = 0; m_act = 0; m_spd = 0; m_since = 0;
      m_en = 0; m_da = 0; m_dbd = 0; m_fault = 0; m_trip = 0;
    end else begin
      n = 0; c = 0;
      for (int i = 0; i < 4; i++) if (mdb[i]) begin n++; c = i + 1; end
      if (n != 1) c = 0;
`ifdef UGV_SEQ_WATCHDOG_EN
      if (m_trip) c = 0;
`endif
      tick = ((m_age % RS) == RS - 1);
      np = m_phase;
      case (m_phase)
        0: if (c != 0) begin
             m_act = c; {m_da, m_dbd} = dirs_of(c); m_en = 1; np = 1;
           end
        1: if (c != m_act) np = 2;
           else if (tick) begin
             if (m_spd < int'(bus.speed_max)) m_spd++;
             else if (m_spd > int'(bus.speed_max)) m_spd--;
           end
        2: if (c == m_act) np = 1;
           else if (tick) begin
             if (m_spd == 0) begin np = 3; m_en = 0; end
             else m_spd--;
           end
        default: if (m_age == SH - 1) np = 0;
      endcase
      m_fault = (n > 1);
`ifdef UGV_SEQ_WATCHDOG_EN
      m_fault = m_fault | m_trip;
      if (bus.heartbeat) begin m_since = 0; m_trip = 0; end
      else begin
        if (m_since >= WD - 1) m_trip = 1;
        m_since++;
      end
`endif
      m_age   = (np != m_phase) ? 0 : m_age + 1;
      m_phase = np;
      // synchronised sample at this edge is the raw level from two edges back
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DB; k++) if (hist[i][k] == mdb[i]) all_diff = 1'b0;
        if (all_diff) mdb[i] = ~mdb[i];
        hist[i] = {hist[i][DB-1:0], raw[i]};
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit       prev_en = 1'b0;
  bit [1:0] prev_dirs = 2'b00;

  always @(negedge clk) begin : compare
    logic [8:0] got, want;
    got  = {bus.speed_code, bus.motor_en, bus.dir_a, bus.dir_b, bus.state, bus.fault};
    want = {2'(m_spd), m_en, m_da, m_dbd, 3'(m_phase), m_fault};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL model_cycle t=%0t got spd/en/a/b/st/flt=%b want=%b", $time, got, want);
    end
    if (prev_en && bus.motor_en) begin
      total++;
      if ({bus.dir_a, bus.dir_b} !== prev_dirs) begin
        bad++;
        $display("FAIL dirs_stable t=%0t got=%b want=%b", $time, {bus.dir_a, bus.dir_b}, prev_dirs);
      end
    end
    prev_en   = bus.motor_en;
    prev_dirs = {bus.dir_a, bus.dir_b};
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  task automatic set_btns(input bit [3:0] b);
    bus.btn_f = b[0]; bus.btn_b = b[1]; bus.btn_l = b[2]; bus.btn_r = b[3];
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int k;
    k = 0;
    while (int'(bus.state) != s && k < budget) begin step(1); k++; end
    check(name, int'(bus.state), s);
  endtask

  task automatic wait_fault(input int budget, input string name);
    int k;
    k = 0;
    while (bus.fault !== 1'b1 && k < budget) begin step(1); k++; end
    check(name, int'(bus.fault), 1);
  endtask

`ifdef UGV_SEQ_WATCHDOG_EN
  initial begin : heartbeat_gen
    bus.heartbeat = 1'b0;
    forever begin
      step(15);
      bus.heartbeat = hb_en;
      step(1);
      bus.heartbeat = 1'b0;
    end
  end
`endif

  initial begin : watchdog_timer
    #1_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    bit [3:0] pat;
    int sel, hold, a, b, g;
    set_btns(4'b0001);
    bus.speed_max = 2'd3;

    // reset with F held
    step(3);
    check("rst_speed", int'(bus.speed_code), 0);
    check("rst_en",    int'(bus.motor_en), 0);
    check("rst_dirs",  int'({bus.dir_a, bus.dir_b}), 0);
    check("rst_state", int'(bus.state), 0);
    check("rst_fault", int'(bus.fault), 0);
    reset = 1'b0;
    step(6);
    check("lat_en_early", int'(bus.motor_en), 0);
    step(1);
    check("lat_en",    int'(bus.motor_en), 1);
    check("lat_dirs",  int'({bus.dir_a, bus.dir_b}), 3);
    check("lat_state", int'(bus.state), 1);

    // ramp up 0,1,2,3 at 8-cycle intervals
    step(7);  check("ramp_0", int'(bus.speed_code), 0);
    step(1);  check("ramp_1", int'(bus.speed_code), 1);
    step(8);  check("ramp_2", int'(bus.speed_code), 2);
    step(8);  check("ramp_3", int'(bus.speed_code), 3);
    step(16); check("ramp_sat", int'(bus.speed_code), 3);

    // direction change F -> B
    set_btns(4'b0010);
    step(7);  check("rdn_state", int'(bus.state), 2);
              check("rdn_spd3", int'(bus.speed_code), 3);
    step(8);  check("rdn_spd2", int'(bus.speed_code), 2);
    step(16); check("rdn_spd0", int'(bus.speed_code), 0);
              check("rdn_en",   int'(bus.motor_en), 1);
    step(8);  check("hold_state", int'(bus.state), 3);
              check("hold_en",    int'(bus.motor_en), 0);
    step(15); check("hold_end", int'(bus.state), 3);
    step(1);  check("idle_after_hold", int'(bus.state), 0);
    step(1);  check("rev_state", int'(bus.state), 1);
              check("rev_dirs",  int'({bus.dir_a, bus.dir_b}), 0);
              check("rev_en",    int'(bus.motor_en), 1);

    // two buttons from IDLE
    set_btns(4'b0000);
    wait_state(0, 200, "to_idle_1");
    set_btns(4'b1100);
    step(8);  check("multi_fault", int'(bus.fault), 1);
              check("multi_idle",  int'(bus.state), 0);
    step(20); check("multi_still_idle", int'(bus.state), 0);
    set_btns(4'b0000);
    step(10); check("multi_clear", int'(bus.fault), 0);

    // two buttons during RUN, then release the extra one
    set_btns(4'b0001);
    wait_state(1, 30, "run_f");
    step(10);
    set_btns(4'b0101);
    wait_state(2, 20, "multi_rdn");
    check("multi_rdn_fault", int'(bus.fault), 1);
    set_btns(4'b0001);
    wait_state(1, 20, "multi_back_run");
    check("multi_back_fault", int'(bus.fault), 0);

    // short glitch is filtered
    set_btns(4'b0000);
    wait_state(0, 300, "to_idle_2");
    set_btns(4'b0001);
    step(3);
    set_btns(4'b0000);
    step(20); check("glitch_idle", int'(bus.state), 0);

    // resume from RAMP_DOWN without hold
    set_btns(4'b0001);
    wait_state(1, 20, "run_again");
    step(30);
    set_btns(4'b0000);
    wait_state(2, 20, "rdn_again");
    set_btns(4'b0001);
    wait_state(1, 20, "resume_run");
    check("resume_en", int'(bus.motor_en), 1);

    // random traffic
    pat = 4'b0001;
    for (int it = 0; it < 80; it++) begin
      sel  = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 60));
      if ($urandom_range(0, 3) == 0) bus.speed_max = 2'($urandom_range(0, 3));
      if (sel <= 5) begin
        pat = 4'b0000; a = int'($urandom_range(0, 3)); pat[a] = 1'b1;
      end else if (sel == 6) begin
        pat = 4'b0000; a = int'($urandom_range(0, 3)); b = int'($urandom_range(0, 3));
        pat[a] = 1'b1; pat[b] = 1'b1;
      end else if (sel == 7) begin
        pat = 4'b0000;
      end else begin
        a = int'($urandom_range(0, 3)); g = int'($urandom_range(1, DB - 1));
        pat[a] = ~pat[a];
        set_btns(pat);
        step(g);
        pat[a] = ~pat[a];
      end
      set_btns(pat);
      step(hold);
    end

`ifdef UGV_SEQ_WATCHDOG_EN
    // heartbeat loss during RUN
    set_btns(4'b0000);
    wait_state(0, 500, "wd_idle");
    set_btns(4'b0001);
    wait_state(1, 30, "wd_run");
    hb_en = 1'b0;
    wait_fault(200, "wd_fault");
    wait_state(3, 100, "wd_hold");
    wait_state(0, 40, "wd_idle_after");
    step(30);
    check("wd_no_restart", int'(bus.state), 0);
    check("wd_fault_held", int'(bus.fault), 1);
    hb_en = 1'b1;
    wait_state(1, 40, "wd_restart");
    check("wd_fault_clear", int'(bus.fault), 0);
`endif

    set_btns(4'b0000);
    step(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ugv_cmd_sequencer.md
Name: ugv_cmd_sequencer

Overview:
Upstream command stage for the UGV motor PWM/bridge stage. Takes four raw direction buttons (F/B/L/R), synchronises and debounces them, and decodes them into a single motion command. Produces per-motor direction bits, a motor enable and a 2-bit speed code that ramps one step at a time. Enforces ramp-down plus a hold interval before any direction change, so the bridge never reverses at speed.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a button level change (>=2)
RAMP_STEP_CYCLES, 250000, clk cycles per speed-code step (>=2)
STOP_HOLD_CYCLES, 100000, cycles motor_en held low after ramp-down before a new command is accepted (>=2)
WDOG_CYCLES, 5000000, heartbeat timeout; used only with UGV_SEQ_WATCHDOG_EN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_f  in  1  forward button, asynchronous, active-high
btn_b  in  1  reverse button, asynchronous, active-high
btn_l  in  1  left button, asynchronous, active-high
btn_r  in  1  right button, asynchronous, active-high
speed_max  in  2  target speed code, synchronous to clk (0=25%..3=100% downstream)
speed_code  out  2  current speed code to the PWM stage
motor_en  out  1  1 = PWM stage may drive the bridge; 0 = all bridge inputs low
dir_a  out  1  motor A direction, 1 = forward
dir_b  out  1  motor B direction, 1 = forward
state  out  3  FSM state encoding, for debug
fault  out  1  high while more than one debounced button is asserted (or watchdog tripped)

Behaviour:
- Clock clk; reset is synchronous, active-high. On reset: speed_code=0, motor_en=0, dir_a=0, dir_b=0, fault=0, state=IDLE, all synchronisers, debounced levels and counters 0.
- Per button: 2-FF synchroniser, then debounce. The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it. Latency from a clean edge to the debounced edge is 2+DEBOUNCE_CYCLES cycles.
- Decode of the debounced inputs:
  - Exactly one asserted: F=FWD (a=1,b=1), B=REV (a=0,b=0), L=LEFT (a=0,b=1), R=RIGHT (a=1,b=0).
  - None asserted: NONE.
  - More than one asserted: NONE, and fault=1 for as long as the condition holds.
- Ramp tick: a prescaler that clears on every state transition; tick when count==RAMP_STEP_CYCLES-1.
- FSM:
  - IDLE: motor_en=0, speed_code=0. On any cmd other than NONE: latch active_cmd, drive the dirs from it, set motor_en=1 and go to RUN next cycle.
  - RUN: if cmd==active_cmd, then on each tick speed_code moves one step toward speed_max (up or down) and holds when equal. Any cmd!=active_cmd, including NONE or fault, goes to RAMP_DOWN.
  - RAMP_DOWN: dirs held. On each tick: if speed_code==0 go to HOLD, otherwise decrement speed_code. If cmd returns to active_cmd, go back to RUN with no hold.
  - HOLD: motor_en=0, speed_code=0, dirs held. Count STOP_HOLD_CYCLES, then go to IDLE. Commands are ignored during HOLD.
- The dirs change only on the IDLE->RUN transition; they never change while motor_en=1.
- A change of speed_max mid-ramp takes effect at the next tick. speed_code never wraps: it saturates at 0 and 3.
- Counter widths are $clog2 of the corresponding parameter.

Optional Feature:
Macro UGV_SEQ_WATCHDOG_EN.
- Defined: adds input heartbeat (1 bit, synchronous single-cycle pulse). A counter clears on each heartbeat and otherwise counts up. On reaching WDOG_CYCLES-1, wdog_trip sets:
  - it forces the decoded cmd to NONE, so RUN goes to RAMP_DOWN and then HOLD;
  - it sets fault=1;
  - IDLE accepts no command while it is set;
  - the next heartbeat clears it.
  - reset clears it.
- Undefined: no heartbeat port, no timeout logic, fault reflects only the multi-button condition.

Decomposition:
Package ugv_pkg holds:
- cmd enum: CMD_NONE, CMD_FWD, CMD_REV, CMD_LEFT, CMD_RIGHT;
- state enum: IDLE=0, RUN=1, RAMP_DOWN=2, HOLD=3;
- speed-code constants SPD_MIN=0, SPD_MAX=3;
- a function mapping cmd to {dir_a,dir_b}.

One sub-module, ugv_debounce: a 1-bit synchroniser plus debouncer, parameter DEBOUNCE_CYCLES, instantiated four times.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, RAMP_STEP_CYCLES=8, STOP_HOLD_CYCLES=16.
1. Reset with btn_f high -> all outputs 0 and state=IDLE while reset is high; after release, motor_en=1 and dir_a=dir_b=1 at 2+4+1 cycles.
2. Hold btn_f with speed_max=3 -> speed_code steps 0,1,2,3 at 8-cycle intervals, then holds at 3.
3. From RUN FWD at speed 3, switch to btn_b -> speed_code 3,2,1,0 every 8 cycles, then motor_en=0 for 16 cycles, then IDLE, then dir_a=dir_b=0 and motor_en=1. The dirs never change while motor_en=1.
4. Press btn_l and btn_r together -> fault=1, no motion from IDLE. If this happens in RUN -> RAMP_DOWN; fault clears once one button is released.
5. Glitch btn_f high for 3 cycles -> debounced level unchanged, state stays IDLE. In RAMP_DOWN, re-asserting the original button -> returns to RUN without entering HOLD.
6. With UGV_SEQ_WATCHDOG_EN and WDOG_CYCLES=64: stop heartbeats during RUN -> fault=1 at the timeout, ramp-down then HOLD then IDLE, and no restart until the next heartbeat.
